// File: rtl/fetch_stage_bpu_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package fetch_stage_bpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } if_id_t;

  // Two-bit saturating step toward the resolved direction.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
    else       return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_stage_bpu_btb.sv
// Direct-mapped BTB: combinational lookup port, one clocked update port.
module branch_target_buffer
  import fetch_stage_bpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic             unused_lsbs;

  assign l_idx = lookup_pc_i[IDX_W+1:2];
  assign l_tag = lookup_pc_i[XLEN-1:IDX_W+2];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign unused_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken_o  = l_hit && ctr_q[l_idx][1];
  assign pred_target_o = target_q[l_idx];
  assign u_hit         = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_valid_i) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], upd_taken_i);
      end else if (upd_taken_i) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= CTR_WT;
      end
    end
  end

  // Tag and target are guarded by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      target_q[u_idx] <= upd_target_i & ALIGN_MASK;
      if (!u_hit) tag_q[u_idx] <= u_tag;
    end
  end

endmodule

// File: rtl/fetch_stage_bpu.sv
// Fetch stage: PC, BTB-based next-PC prediction and the IF/ID pipeline register.
module fetch_stage_bpu
  import fetch_stage_bpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] NOP_INSTR   = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            resolve_valid_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  input  logic [XLEN-1:0] resolve_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic            if_id_valid_o,
  output logic            if_id_pred_taken_o,
  output logic [XLEN-1:0] if_id_pred_pc_o
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, next_pc, btb_target;
  logic            btb_taken;
  if_id_t          if_id_q, if_id_d;

  branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (pc_q),
    .pred_taken_o (btb_taken),
    .pred_target_o(btb_target),
    .upd_valid_i  (resolve_valid_i),
    .upd_pc_i     (resolve_pc_i),
    .upd_taken_i  (resolve_taken_i),
    .upd_target_i (resolve_target_i)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = btb_taken ? btb_target : pc_plus4;

  // Redirect beats stall: a flush must land even while the hazard unit holds fetch.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (redirect_i) begin
      pc_d               = redirect_pc_i & ALIGN_MASK;
      if_id_d.valid      = 1'b0;
      if_id_d.instr      = NOP_INSTR;
      if_id_d.pred_taken = 1'b0;
    end else if (!stall_i) begin
      pc_d    = next_pc;
      if_id_d = '{pc: pc_q, instr: imem_rdata_i, valid: 1'b1,
                  pred_taken: btb_taken, pred_pc: next_pc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0, pred_taken: 1'b0, pred_pc: '0};
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr_o        = pc_q;
  assign if_id_pc_o         = if_id_q.pc;
  assign if_id_instr_o      = if_id_q.instr;
  assign if_id_valid_o      = if_id_q.valid;
  assign if_id_pred_taken_o = if_id_q.pred_taken;
  assign if_id_pred_pc_o    = if_id_q.pred_pc;

endmodule

// File: tb/tb_fetch_stage_bpu.sv
// Directed bench for fetch_stage_bpu: reset, sequential fetch, BTB training and fetch priority.
module tb_fetch_stage_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, resolve_valid_i, resolve_taken_i;
  logic [31:0] redirect_pc_i, resolve_pc_i, resolve_target_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] if_id_pc_o, if_id_instr_o, if_id_pred_pc_o;
  logic        if_id_valid_o, if_id_pred_taken_o;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = 32'hA0 + imem_addr_o;

  // {if_id_pc, if_id_instr, valid, pred_taken, pred_pc, imem_addr}
  logic [129:0] obs;
  assign obs = {if_id_pc_o, if_id_instr_o, if_id_valid_o, if_id_pred_taken_o,
                if_id_pred_pc_o, imem_addr_o};

  fetch_stage_bpu #(
    .RESET_PC(32'h0), .BTB_ENTRIES(16), .NOP_INSTR(32'h13)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .resolve_valid_i   (resolve_valid_i),
    .resolve_pc_i      (resolve_pc_i),
    .resolve_taken_i   (resolve_taken_i),
    .resolve_target_i  (resolve_target_i),
    .imem_addr_o       (imem_addr_o),
    .imem_rdata_i      (imem_rdata_i),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_valid_o     (if_id_valid_o),
    .if_id_pred_taken_o(if_id_pred_taken_o),
    .if_id_pred_pc_o   (if_id_pred_pc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    resolve_valid_i = 1'b1; resolve_pc_i = pc; resolve_taken_i = taken; resolve_target_i = tgt;
    tick();
    resolve_valid_i = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    logic [34:0] exp;
    redirect_i = 1'b1; redirect_pc_i = a;
    tick();
    redirect_i = 1'b0;
    exp = {32'h13, 1'b0, 1'b0};
    tests_run++;
    if ({if_id_instr_o, if_id_valid_o, if_id_pred_taken_o} !== exp || imem_addr_o !== (a & 32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL redirect_bubble: got instr/v/pt=%h addr=%h want %h addr=%h",
               {if_id_instr_o, if_id_valid_o, if_id_pred_taken_o}, imem_addr_o, exp, a & 32'hFFFF_FFFC);
    end
  endtask

  task automatic fetch_at(input logic [31:0] a);
    redirect_to(a);
    tick();
  endtask

  task automatic test_reset();
    logic [129:0] exp;
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    resolve_valid_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0; resolve_target_i = '0;
    #12;
    exp = {32'h0, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    #5 rst = 1'b1;
  endtask

  task automatic test_run();
    logic [129:0] exp;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {32'(4*i), 32'(32'hA0 + 4*i), 1'b1, 1'b0, 32'(4*i + 4), 32'(4*i + 4)};
      tests_run++;
      if (obs !== exp) begin fails++; $display("FAIL seq_fetch[%0d]: got %h want %h", i, obs, exp); end
    end
  endtask

  task automatic test_alloc();
    logic [129:0] exp;
    resolve(32'h10, 1'b1, 32'h40);
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b1, 32'h40, 32'h40};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL alloc_predict: got %h want %h", obs, exp); end
  endtask

  task automatic test_hysteresis();
    logic [129:0] exp;
    resolve(32'h10, 1'b0, 32'h0);                           // 2 -> 1
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b0, 32'h14, 32'h14};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_weak_nt: got %h want %h", obs, exp); end
    resolve(32'h10, 1'b1, 32'h40);                          // 1 -> 2
    resolve(32'h10, 1'b1, 32'h40);                          // 2 -> 3
    resolve(32'h10, 1'b1, 32'h63);                          // stays 3, target 0x60
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b1, 32'h60, 32'h60};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_strong_t: got %h want %h", obs, exp); end
    resolve(32'h10, 1'b0, 32'h0);                           // 3 -> 2
    fetch_at(32'h10);
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_sat_hi: got %h want %h", obs, exp); end
    resolve(32'h10, 1'b0, 32'h0);                           // 2 -> 1
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b0, 32'h14, 32'h14};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_back_nt: got %h want %h", obs, exp); end
    resolve(32'h10, 1'b0, 32'h0);                           // 1 -> 0
    resolve(32'h10, 1'b0, 32'h0);                           // stays 0
    resolve(32'h10, 1'b1, 32'h40);                          // 0 -> 1
    fetch_at(32'h10);
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_sat_lo: got %h want %h", obs, exp); end
    resolve(32'h10, 1'b1, 32'h40);                          // 1 -> 2
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b1, 32'h40, 32'h40};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL hyst_retrain: got %h want %h", obs, exp); end
  endtask

  task automatic test_priority();
    logic [129:0] exp;
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    tick();
    stall_i = 1'b0; redirect_i = 1'b0;
    exp = {32'h10, 32'h13, 1'b0, 1'b0, 32'h40, 32'h200};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL redirect_over_stall: got %h want %h", obs, exp); end
    tick();
    exp = {32'h200, 32'h2A0, 1'b1, 1'b0, 32'h204, 32'h204};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL post_redirect_fetch: got %h want %h", obs, exp); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (obs !== exp) begin fails++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp); end
    end
    stall_i = 1'b0;
    tick();
    exp = {32'h204, 32'h2A4, 1'b1, 1'b0, 32'h208, 32'h208};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL stall_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_alias();
    logic [129:0] exp;
    resolve(32'h10, 1'b1, 32'h40);
    fetch_at(32'h50);
    exp = {32'h50, 32'hF0, 1'b1, 1'b0, 32'h54, 32'h54};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL alias_miss: got %h want %h", obs, exp); end
    resolve(32'h50, 1'b0, 32'h0);
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b1, 32'h40, 32'h40};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL alias_keep: got %h want %h", obs, exp); end
  endtask

  task automatic test_wrap();
    logic [129:0] exp;
    fetch_at(32'hFFFF_FFFC);
    exp = {32'hFFFF_FFFC, 32'h9C, 1'b1, 1'b0, 32'h0, 32'h0};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL pc_wrap: got %h want %h", obs, exp); end
  endtask

  task automatic test_async_reset();
    logic [129:0] exp;
    tick();
    #2 rst = 1'b0;
    #1;
    exp = {32'h0, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    #3 rst = 1'b1;
    tick();
    exp = {32'h0, 32'hA0, 1'b1, 1'b0, 32'h4, 32'h4};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL restart_fetch: got %h want %h", obs, exp); end
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b0, 32'h14, 32'h14};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL btb_cleared: got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [129:0] exp;
    redirect_to(32'h10);
    resolve(32'h10, 1'b1, 32'h40);
    exp = {32'h10, 32'hB0, 1'b1, 1'b0, 32'h14, 32'h14};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL same_cycle_war: got %h want %h", obs, exp); end
    fetch_at(32'h10);
    exp = {32'h10, 32'hB0, 1'b1, 1'b1, 32'h40, 32'h40};
    tests_run++;
    if (obs !== exp) begin fails++; $display("FAIL update_visible: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_alloc();
    test_hysteresis();
    test_priority();
    test_alias();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
